// File: rtl/wb_pkg.sv
// Shared types and sizes for the writeback stage.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 2 ** REG_ADDR_W;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_result_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending tracker plus operand busy/forward lookup for decode.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic                  wr_en_i,
    input  logic [REG_ADDR_W-1:0] wr_reg_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  rs1_fwd_o,
    output logic                  rs2_fwd_o,
    output logic                  any_pending_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic             rs1_match;
    logic             rs2_match;
    logic             rs1_reissue;
    logic             rs2_reissue;

    // Next pending vector: clear on write-back, then set on issue so a newer producer wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_en_i) begin
            pending_d[wr_reg_i] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != '0)) begin
            pending_d[issue_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Pending register state; in-flight tracking is discarded on reset.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // A result on the write port satisfies an operand unless decode is re-issuing the same rd now.
    assign rs1_match   = wr_en_i && (wr_reg_i == rs1_addr_i) && (rs1_addr_i != '0);
    assign rs2_match   = wr_en_i && (wr_reg_i == rs2_addr_i) && (rs2_addr_i != '0);
    assign rs1_reissue = issue_valid_i && (issue_rd_i == rs1_addr_i);
    assign rs2_reissue = issue_valid_i && (issue_rd_i == rs2_addr_i);

    assign rs1_fwd_o  = rs1_match;
    assign rs2_fwd_o  = rs2_match;
    assign rs1_busy_o = (rs1_addr_i != '0) && pending_q[rs1_addr_i] && (!rs1_match || rs1_reissue);
    assign rs2_busy_o = (rs2_addr_i != '0) && pending_q[rs2_addr_i] && (!rs2_match || rs2_reissue);

    assign any_pending_o = |pending_q;

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: round-robin ALU/load arbiter, registered register-file write port,
// RAW scoreboard and single-cycle forward of the value being written.
module writeback_unit
    import wb_pkg::*;
(
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [REG_ADDR_W-1:0] alu_rd_i,
    input  logic [XLEN-1:0]       alu_data_i,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic [XLEN-1:0]       mem_data_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  rs1_fwd_o,
    output logic                  rs2_fwd_o,
    output logic [XLEN-1:0]       fwd_data_o,
    output logic                  rf_write_enable_o,
    output logic [REG_ADDR_W-1:0] rf_write_register_o,
    output logic [XLEN-1:0]       rf_write_data_o,
    output logic                  idle_o
);

    wb_src_e               rr_last_q;
    logic                  grant_alu;
    logic                  grant_mem;
    logic                  accept;
    wb_result_t            sel;
    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_reg_q;
    logic [XLEN-1:0]       rf_data_q;
    logic                  any_pending;

    // Round-robin grant: a lone requester always wins, on contention the last loser wins.
    always_comb begin
        grant_alu = alu_valid_i && (!mem_valid_i || (rr_last_q == WB_SRC_MEM));
        grant_mem = mem_valid_i && !grant_alu;
        accept    = grant_alu || grant_mem;
        sel.rd    = grant_alu ? alu_rd_i   : mem_rd_i;
        sel.data  = grant_alu ? alu_data_i : mem_data_i;
    end

    assign alu_ready_o = grant_alu;
    assign mem_ready_o = grant_mem;

    // Arbiter history and write-port register; x0 results are accepted but never written.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_last_q <= WB_SRC_MEM;
            rf_we_q   <= 1'b0;
            rf_reg_q  <= '0;
            rf_data_q <= '0;
        end else begin
            if (grant_alu) begin
                rr_last_q <= WB_SRC_ALU;
            end else if (grant_mem) begin
                rr_last_q <= WB_SRC_MEM;
            end
            rf_we_q <= accept && (sel.rd != '0);
            if (accept && (sel.rd != '0)) begin
                rf_reg_q  <= sel.rd;
                rf_data_q <= sel.data;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clock_i       (clock_i),
        .reset_n_i     (reset_n_i),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .wr_en_i       (rf_we_q),
        .wr_reg_i      (rf_reg_q),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .rs1_busy_o    (rs1_busy_o),
        .rs2_busy_o    (rs2_busy_o),
        .rs1_fwd_o     (rs1_fwd_o),
        .rs2_fwd_o     (rs2_fwd_o),
        .any_pending_o (any_pending)
    );

    assign rf_write_enable_o   = rf_we_q;
    assign rf_write_register_o = rf_reg_q;
    assign rf_write_data_o     = rf_data_q;
    assign fwd_data_o          = rf_data_q;
    assign idle_o              = !any_pending && !rf_we_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: arbitration, write-port latency, scoreboard and forwarding.
module tb_writeback_unit;
    import wb_pkg::*;

    logic                  clock;
    logic                  reset_n;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]       mem_data;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  rs1_fwd;
    logic                  rs2_fwd;
    logic [XLEN-1:0]       fwd_data;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_reg;
    logic [XLEN-1:0]       rf_data;
    logic                  idle;

    int errors = 0;
    int checks = 0;

    writeback_unit dut (
        .clock_i             (clock),
        .reset_n_i           (reset_n),
        .issue_valid_i       (issue_valid),
        .issue_rd_i          (issue_rd),
        .alu_valid_i         (alu_valid),
        .alu_ready_o         (alu_ready),
        .alu_rd_i            (alu_rd),
        .alu_data_i          (alu_data),
        .mem_valid_i         (mem_valid),
        .mem_ready_o         (mem_ready),
        .mem_rd_i            (mem_rd),
        .mem_data_i          (mem_data),
        .rs1_addr_i          (rs1_addr),
        .rs2_addr_i          (rs2_addr),
        .rs1_busy_o          (rs1_busy),
        .rs2_busy_o          (rs2_busy),
        .rs1_fwd_o           (rs1_fwd),
        .rs2_fwd_o           (rs2_fwd),
        .fwd_data_o          (fwd_data),
        .rf_write_enable_o   (rf_we),
        .rf_write_register_o (rf_reg),
        .rf_write_data_o     (rf_data),
        .idle_o              (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid = 1'b0;
        issue_rd    = '0;
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_rd      = '0;
        mem_data    = '0;
        rs1_addr    = '0;
        rs2_addr    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        reset_n = 1'b1;
        clear_inputs();
        #2;
        do_reset();

        // Reset state
        check_eq("rst_we", rf_we, 0);
        check_eq("rst_reg", rf_reg, 0);
        check_eq("rst_data", rf_data, 0);
        check_eq("rst_idle", idle, 1);

        // 1: single ALU result, latency one
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; rs1_addr = 5'd5;
        #1;
        check_eq("t1_alu_ready", alu_ready, 1);
        check_eq("t1_mem_ready", mem_ready, 0);
        check_eq("t1_we_before", rf_we, 0);
        step();
        alu_valid = 1'b0;
        #1;
        check_eq("t1_we", rf_we, 1);
        check_eq("t1_reg", rf_reg, 5);
        check_eq("t1_data", rf_data, 32'hDEADBEEF);
        check_eq("t1_fwd_data", fwd_data, 32'hDEADBEEF);
        check_eq("t1_rs1_fwd", rs1_fwd, 1);
        check_eq("t1_rs1_busy", rs1_busy, 0);
        check_eq("t1_idle_busy", idle, 0);
        step();
        check_eq("t1_we_off", rf_we, 0);
        check_eq("t1_reg_hold", rf_reg, 5);
        check_eq("t1_idle_back", idle, 1);

        // 2: contention, round-robin ALU, MEM, ALU
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_00A1;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h0000_00B2;
        #1;
        check_eq("t2_c1_alu", alu_ready, 1);
        check_eq("t2_c1_mem", mem_ready, 0);
        step();
        check_eq("t2_c1_reg", rf_reg, 1);
        check_eq("t2_c1_data", rf_data, 32'h0000_00A1);
        check_eq("t2_c2_alu", alu_ready, 0);
        check_eq("t2_c2_mem", mem_ready, 1);
        step();
        check_eq("t2_c2_reg", rf_reg, 2);
        check_eq("t2_c2_data", rf_data, 32'h0000_00B2);
        check_eq("t2_c3_alu", alu_ready, 1);
        check_eq("t2_c3_mem", mem_ready, 0);
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        check_eq("t2_c3_reg", rf_reg, 1);
        check_eq("t2_c3_we", rf_we, 1);
        step();

        // 3: RAW on x7 resolved by forward
        issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd0;
        #1;
        check_eq("t3_busy_issue_cyc", rs1_busy, 0);
        step();
        issue_valid = 1'b0;
        #1;
        check_eq("t3_busy_1", rs1_busy, 1);
        check_eq("t3_idle_pend", idle, 0);
        check_eq("t3_rs2_zero_busy", rs2_busy, 0);
        step();
        check_eq("t3_busy_2", rs1_busy, 1);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0777;
        #1;
        check_eq("t3_busy_accept", rs1_busy, 1);
        check_eq("t3_fwd_accept", rs1_fwd, 0);
        step();
        alu_valid = 1'b0;
        #1;
        check_eq("t3_busy_wr", rs1_busy, 0);
        check_eq("t3_fwd_wr", rs1_fwd, 1);
        check_eq("t3_fwd_data", fwd_data, 32'h0000_0777);
        step();
        check_eq("t3_busy_after", rs1_busy, 0);
        check_eq("t3_fwd_after", rs1_fwd, 0);
        check_eq("t3_idle_after", idle, 1);

        // 4: re-issue x3 while x3 is being written; set wins
        issue_valid = 1'b1; issue_rd = 5'd3; rs1_addr = 5'd3;
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0333;
        step();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd3;
        #1;
        check_eq("t4_we", rf_we, 1);
        check_eq("t4_busy_reissue", rs1_busy, 1);
        check_eq("t4_fwd_reissue", rs1_fwd, 1);
        step();
        issue_valid = 1'b0;
        #1;
        check_eq("t4_busy_after", rs1_busy, 1);
        check_eq("t4_idle_after", idle, 0);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0334;
        step();
        alu_valid = 1'b0;
        step();
        check_eq("t4_busy_drained", rs1_busy, 0);
        check_eq("t4_idle_drained", idle, 1);

        // 5: result for x0 accepted and dropped
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_1234;
        #1;
        check_eq("t5_mem_ready", mem_ready, 1);
        step();
        mem_valid = 1'b0;
        #1;
        check_eq("t5_we", rf_we, 0);
        check_eq("t5_idle", idle, 1);

        // 6: asynchronous reset mid-cycle with pending regs and an active write
        issue_valid = 1'b1; issue_rd = 5'd4;
        step();
        issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h0000_0C0C;
        step();
        alu_valid = 1'b0;
        rs1_addr = 5'd4; rs2_addr = 5'd9;
        #1;
        check_eq("t6_we_pre", rf_we, 1);
        check_eq("t6_rs1_busy_pre", rs1_busy, 1);
        check_eq("t6_rs2_busy_pre", rs2_busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_we_rst", rf_we, 0);
        check_eq("t6_rs1_busy_rst", rs1_busy, 0);
        check_eq("t6_rs2_busy_rst", rs2_busy, 0);
        check_eq("t6_idle_rst", idle, 1);
        step();
        reset_n = 1'b1;
        step();
        check_eq("t6_rs1_busy_post", rs1_busy, 0);
        check_eq("t6_idle_post", idle, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
